// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_arb_pkg: shared definitions for the FIFO write-port arbiter.
//   arb_state_e : arbiter FSM encoding (IDLE / BURST / ROTATE)
//   CNT_MAX     : saturation value of the optional per-producer word counters
//   wrap_inc    : modulo-n increment used for the round-robin pointer
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BURST  = 2'd1,
    ROTATE = 2'd2
  } arb_state_e;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // Next index after v in a ring of n entries.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    if (v + 32'd1 >= n) begin
      return 32'd0;
    end else begin
      return v + 32'd1;
    end
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: producer/FIFO-facing bundle of the write arbiter.
//   req, req_data  : producer requests and their packed words
//   ack            : one-hot "word consumed" pulse back to the producers
//   fifo_full      : FIFO full flag
//   fifo_we        : FIFO write enable
//   fifo_data      : FIFO write data
//   grant_valid/id : current burst owner
// Modports: slave = arbiter view, master = producers + FIFO view.
interface fifo_wr_arbiter_if #(
  parameter int width    = 16,
  parameter int num_req  = 4,
  parameter int id_width = $clog2(num_req)
);
  logic [num_req-1:0]       req;
  logic [num_req*width-1:0] req_data;
  logic [num_req-1:0]       ack;
  logic                     fifo_full;
  logic                     fifo_we;
  logic [width-1:0]         fifo_data;
  logic                     grant_valid;
  logic [id_width-1:0]      grant_id;

  modport slave (
    input  req, req_data, fifo_full,
    output ack, fifo_we, fifo_data, grant_valid, grant_id
  );

  modport master (
    output req, req_data, fifo_full,
    input  ack, fifo_we, fifo_data, grant_valid, grant_id
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// rr_picker: combinational round-robin search.
//   i_req   : request vector
//   i_ptr   : index the search starts from
//   o_found : at least one request is set
//   o_idx   : first set request at or above i_ptr, wrapping to 0
module rr_picker #(
  parameter int num_req  = 4,
  parameter int id_width = $clog2(num_req)
) (
  input  logic [num_req-1:0]  i_req,
  input  logic [id_width-1:0] i_ptr,
  output logic                o_found,
  output logic [id_width-1:0] o_idx
);

  // Walk the ring once starting at i_ptr; the first hit wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int k = 0; k < num_req; k++) begin
      int unsigned j;
      j = (32'(i_ptr) + 32'(k)) % 32'(num_req);
      if (!o_found && i_req[j]) begin
        o_found = 1'b1;
        o_idx   = id_width'(j);
      end else begin
        o_found = o_found;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares one FIFO write port among num_req producers with
// round-robin arbitration and bursts of at most max_burst words.
//   clk, rst : clock and synchronous active-high reset
//   bus      : fifo_wr_arbiter_if.slave (requests, acks, FIFO write side, grant)
//   word_cnt : per-producer 16-bit saturating ack counters, present only when
//              the macro FIFO_ARB_WORD_CNT_EN is defined
// Writes are combinational (zero-latency) from state, req and fifo_full, so a
// full FIFO blocks the write in the same cycle it is flagged.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int width     = 16,
  parameter int num_req   = 4,
  parameter int max_burst = 4,
  parameter int id_width  = $clog2(num_req)
) (
  input  logic                    clk,
  input  logic                    rst,
  fifo_wr_arbiter_if.slave        bus
`ifdef FIFO_ARB_WORD_CNT_EN
  ,
  output logic [num_req*16-1:0]   word_cnt
`endif
);

  localparam int CNT_W = $clog2(max_burst + 1);

  arb_state_e          r_state, w_next_state;
  logic [id_width-1:0] r_ptr, w_next_ptr;
  logic [id_width-1:0] r_owner, w_next_owner;
  logic [CNT_W-1:0]    r_cnt, w_next_cnt;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic                w_pick_found;
  logic [id_width-1:0] w_pick_idx;
  logic                w_we;
  logic [id_width-1:0] w_writer;
  logic [num_req-1:0]  w_ack;

  rr_picker #(
    .num_req  (num_req),
    .id_width (id_width)
  ) u_picker (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .o_found (w_pick_found),
    .o_idx   (w_pick_idx)
  );

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_ptr   <= w_next_ptr;
      r_owner <= w_next_owner;
      r_cnt   <= w_next_cnt;
    end
  end

  // Next-state and write decision.
  always_comb begin
    w_next_state = r_state;
    w_next_ptr   = r_ptr;
    w_next_owner = r_owner;
    w_next_cnt   = r_cnt;
    w_we         = 1'b0;
    w_writer     = r_owner;
    if (rst) begin
      // Nothing is written while reset is held, even if requests are present.
      w_we = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!bus.fifo_full && w_pick_found) begin
            w_we         = 1'b1;
            w_writer     = w_pick_idx;
            w_next_owner = w_pick_idx;
            w_next_cnt   = CNT_W'(1);
            w_next_state = (max_burst == 1) ? ROTATE : BURST;
          end else begin
            w_next_state = IDLE;
          end
        end
        BURST: begin
          if (!bus.req[r_owner]) begin
            // Owner gave up: the rest of its burst is forfeited.
            w_next_state = ROTATE;
          end else if (bus.fifo_full) begin
            // Stall but keep the grant.
            w_next_state = BURST;
          end else if (r_cnt < CNT_W'(max_burst)) begin
            w_we       = 1'b1;
            w_next_cnt = w_cnt_inc;
            w_next_state = (w_cnt_inc == CNT_W'(max_burst)) ? ROTATE : BURST;
          end else begin
            // Burst length already exhausted; cannot normally be reached.
            w_next_state = ROTATE;
          end
        end
        ROTATE: begin
          w_next_ptr   = id_width'(wrap_inc(32'(r_owner), 32'(num_req)));
          w_next_cnt   = '0;
          w_next_state = IDLE;
        end
        default: begin
          w_next_state = IDLE;
          w_next_cnt   = '0;
        end
      endcase
    end
  end

  assign w_ack           = w_we ? (num_req'(1'b1) << w_writer) : '0;
  assign bus.ack         = w_ack;
  assign bus.fifo_we     = w_we;
  assign bus.fifo_data   = w_we ? bus.req_data[w_writer*width +: width] : '0;
  // Grant outputs come from registers but read as zero during the reset cycle.
  assign bus.grant_valid = !rst && ((r_state == BURST) || (r_state == ROTATE));
  assign bus.grant_id    = rst ? '0 : r_owner;

`ifdef FIFO_ARB_WORD_CNT_EN
  logic [num_req*16-1:0] r_word_cnt;

  // Per-producer ack counters, saturating at CNT_MAX.
  always_ff @(posedge clk) begin
    for (int i = 0; i < num_req; i++) begin
      if (rst) begin
        r_word_cnt[i*16 +: 16] <= 16'd0;
      end else if (w_ack[i] && (r_word_cnt[i*16 +: 16] != CNT_MAX)) begin
        r_word_cnt[i*16 +: 16] <= r_word_cnt[i*16 +: 16] + 16'd1;
      end else begin
        r_word_cnt[i*16 +: 16] <= r_word_cnt[i*16 +: 16];
      end
    end
  end

  assign word_cnt = r_word_cnt;
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the write port of one FIFO instance among num_req independent producers.
- Uses round-robin arbitration with bounded bursts: a granted producer can write up to max_burst consecutive words before the grant rotates.
- Sits directly in front of the FIFO write side. It drives we/data_in and obeys fifo_full. It never writes while fifo_full is high.

Parameters:
- width, 16, data word width; must equal the FIFO width.
- num_req, 4, number of producers; must be at least 2.
- max_burst, 4, maximum words per grant; must be at least 1.
- id_width, $clog2(num_req), width of the requester index.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  num_req  per-producer request; the producer holds its word valid while this is high.
- req_data  in  num_req*width  packed words; producer i occupies bits [i*width +: width].
- ack  out  num_req  one-hot pulse; the word from producer i is written this cycle, so the producer advances.
- fifo_full  in  1  from the FIFO.
- fifo_we  out  1  to the FIFO we input.
- fifo_data  out  width  to the FIFO data_in input.
- grant_valid  out  1  registered; a burst owner exists.
- grant_id  out  id_width  registered; the current owner, valid only when grant_valid is high.

Behaviour:
- States: IDLE, BURST, ROTATE.
  - Registers: state, ptr (id_width), owner (id_width), cnt ($clog2(max_burst+1)).
- Reset values while rst is high and on the following edge:
  - state=IDLE, ptr=0, owner=0, cnt=0.
  - grant_valid=0, grant_id=0.
  - fifo_we=0, ack=0, fifo_data=0.
- fifo_we, ack and fifo_data are combinational from state, req and fifo_full. There is zero-cycle latency from request to write.
  - ack[i] = fifo_we AND (writer == i).
  - fifo_data = req_data slice of the writer when fifo_we=1, otherwise 0.
- IDLE:
  - If fifo_full=1 or req=0: no write, stay in IDLE.
  - Otherwise the winner is the first i with req[i]=1, searching upward from ptr and wrapping modulo num_req.
  - That cycle: write the winner's word, owner<=winner, cnt<=1.
  - If max_burst=1, go to ROTATE. Otherwise go to BURST.
- BURST:
  - If req[owner]=1, fifo_full=0 and cnt<max_burst: write, cnt<=cnt+1.
    - If the new cnt equals max_burst, go to ROTATE.
  - If req[owner]=1 and fifo_full=1: stall. No write, cnt holds, stay in BURST. The grant is kept across the full condition.
  - If req[owner]=0: no write, go to ROTATE.
  - Requests from non-owners are ignored in BURST and never acked.
- ROTATE:
  - One bubble cycle with no write.
  - ptr<=owner+1, wrapping num_req-1 to 0. cnt<=0. Go to IDLE.
- grant_valid=1 when the registered state is BURST or ROTATE. grant_id=owner.
- Starvation bound: a continuously requesting producer is written within (num_req-1)*(max_burst+1)+1 non-full cycles.
- fifo_full is sampled in the same cycle as the write. The FIFO asserts full combinationally from its pointers, so no overflow is possible.
- Reset mid-burst: all state is cleared, no ack is issued in the reset cycle, and arbitration restarts from ptr=0.
- A producer that drops req mid-burst loses the remainder of its burst. It re-arbitrates normally.

Optional Feature:
- Macro: FIFO_ARB_WORD_CNT_EN.
- With the macro defined:
  - Adds output word_cnt [num_req*16].
  - One 16-bit counter per producer, incremented on each ack and saturating at 16'hFFFF.
  - Cleared by rst.
- Without the macro: the port and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package fifo_arb_pkg holds:
  - The state encoding: IDLE=2'd0, BURST=2'd1, ROTATE=2'd2.
  - Saturation constant CNT_MAX=16'hFFFF.
- One sub-module, rr_picker: combinational.
  - Inputs: req and ptr.
  - Outputs: found and idx, the first set bit at or above ptr, with wrap.
  - Instantiated once.

Test Plan:
- Single requester: num_req=4, max_burst=4, req=4'b0010 held, words 0xA0..0xA5. Required response:
  - fifo_we on cycles 0-3 with data 0xA0..0xA3.
  - Bubble on cycle 4, ptr=2.
  - Cycle 5: the same requester wins again (wrap search), and 0xA4 is written.
- All four requesting continuously, FIFO never full:
  - Grant order is 0,1,2,3,0.
  - Each burst is exactly 4 acks followed by 1 bubble.
  - Every producer receives 4 acks per 20 cycles.
- fifo_full asserted for 3 cycles mid-burst, owner=2, cnt=2:
  - No fifo_we and no ack during those cycles; grant_id stays 2.
  - The remaining 2 words are written after full drops, then ROTATE.
- Owner drops req after 1 word while req[3] is high:
  - ROTATE next cycle, ptr=3.
  - Producer 3 is acked in the cycle after that.
- rst pulsed for 1 cycle during a burst with owner=1:
  - All outputs are 0 in that cycle.
  - Next grant goes to the lowest active index searching from 0.
- With FIFO_ARB_WORD_CNT_EN defined:
  - After the all-requesting run, each counter equals its ack count.
  - Forcing 70000 acks on producer 0 leaves its counter at 0xFFFF.
